par_sng_lanes: RTL and testbench

- Multi-lane deterministic stochastic number generator. Converts a WIDTH-bit binary value into a 2^WIDTH-bit bitstream, emitted LANES bits per cycle.
- Sits directly upstream of the par_acc_<N>lanes accumulators: drives their data_in and issues a counter clear.
- Emits a full-length stream whose total ones count equals the input value exactly.
- Two threshold orderings: unary (counter) and bit-reversed (van der Corput, low-discrepancy).

---
 rtl/par_sng_lanes_if.sv | 26 ++
 rtl/par_sng_lanes.sv | 127 ++++++++++++
 tb/tb_par_sng_lanes.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/par_sng_lanes_if.sv
// rtl/par_sng_lanes_if.sv - request/stream bundle for the multi-lane stochastic number generator
interface par_sng_lanes_if #(
  parameter int LANES = 8,
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] value_in;
  logic             mode_in;
  logic             hold;
  logic             busy;
  logic             acc_clr;
  logic [LANES-1:0] data_out;
  logic             data_valid;
  logic             last;
  logic             done;

  modport master (
    output start, value_in, mode_in, hold,
    input  busy, acc_clr, data_out, data_valid, last, done
  );

  modport slave (
    input  start, value_in, mode_in, hold,
    output busy, acc_clr, data_out, data_valid, last, done
  );
endinterface

// File: rtl/par_sng_lanes.sv
// rtl/par_sng_lanes.sv - deterministic stochastic number generator, LANES stream bits per cycle
// Unary or bit-reversed thresholds; ones count of a full stream equals the latched value.
module par_sng_lanes #(
  parameter int LANES = 8,
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  par_sng_lanes_if.slave bus
);
  localparam int NCYC = (1 << WIDTH) / LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(NCYC - 1);

  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             mode_q, mode_d;
  logic             acc_clr_q, acc_clr_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [LANES-1:0] data_q, data_d;
  logic [LANES-1:0] beat;
  logic             emit;

  // Comparator bank: one threshold per lane for the beat at position cyc_q.
  always_comb begin
    logic [WIDTH-1:0] idx;
    logic [WIDTH-1:0] rev;
    logic [WIDTH-1:0] thr;
    beat = '0;
    for (int i = 0; i < LANES; i++) begin
      idx = WIDTH'(int'(cyc_q) * LANES + i);
      rev = '0;
      for (int b = 0; b < WIDTH; b++) begin
        rev[b] = idx[WIDTH-1-b];
      end
      thr = mode_q ? rev : idx;
      beat[i] = (val_q > thr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      val_q     <= '0;
      mode_q    <= 1'b0;
      acc_clr_q <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      val_q     <= val_d;
      mode_q    <= mode_d;
      acc_clr_q <= acc_clr_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      data_q    <= data_d;
    end
  end

  // last_q marks that the final beat is already on the outputs, so RUN leaves on the next edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CLR;
      CLR:     state_d = RUN;
      RUN:     if (last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat 0 is emitted on the CLR->RUN edge so data follows the clear cycle directly.
  always_comb begin
    acc_clr_d = 1'b0;
    done_d    = 1'b0;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    data_d    = '0;
    cyc_d     = cyc_q;
    val_d     = val_q;
    mode_d    = mode_q;
    emit      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_clr_d = 1'b1;
          val_d     = bus.value_in;
          mode_d    = bus.mode_in;
          cyc_d     = '0;
        end
      end
      CLR: emit = 1'b1;
      RUN: begin
        if (last_q) begin
          done_d = 1'b1;
          cyc_d  = '0;
        end else if (!bus.hold) begin
          emit = 1'b1;
        end
      end
      default: ;
    endcase
    if (emit) begin
      data_d  = beat;
      valid_d = 1'b1;
      last_d  = (cyc_q == CYC_LAST);
      cyc_d   = (cyc_q == CYC_LAST) ? '0 : cyc_q + CW'(1);
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.acc_clr    = acc_clr_q;
  assign bus.done       = done_q;
  assign bus.data_valid = valid_q;
  assign bus.last       = last_q;
  assign bus.data_out   = data_q;
endmodule

// File: tb/tb_par_sng_lanes.sv
// tb/tb_par_sng_lanes.sv - directed self-checking bench for par_sng_lanes (LANES=8, WIDTH=8)
module tb_par_sng_lanes;
  localparam int LANES = 8;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  par_sng_lanes_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();
  par_sng_lanes #(.LANES(LANES), .WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int ntests = 0;
  int nfail  = 0;

  logic [7:0] beats [32];
  int nbeats, ones, last_beat, last_count, first_k, span, held_invalid, bad_zero, done_count;
  bit clr_ok, got_done, done_after_last, done_busy, busy_after, done_after, rst_seen;
  logic [3:0] rst_after, rst_after2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; runs one stream and records what it saw.
  task automatic run_stream(input logic [7:0] v, input logic m, input int hold_at,
                            input int hold_len, input int rst_at, input bit poke);
    int held = 0;
    int last_k = -10;
    nbeats = 0; ones = 0; last_beat = -1; last_count = 0; first_k = -1; span = 0;
    held_invalid = 0; bad_zero = 0; done_count = 0; got_done = 0; done_after_last = 0;
    done_busy = 0; busy_after = 1; done_after = 1; rst_seen = 0; rst_after = 4'hF; rst_after2 = 4'hF;
    for (int b = 0; b < 32; b++) beats[b] = 8'hXX;
    bus.value_in = v; bus.mode_in = m; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.value_in = ~v; bus.mode_in = ~m;
    clr_ok = bus.acc_clr && bus.busy && !bus.data_valid && (bus.data_out == 0);
    for (int k = 0; k < 80; k++) begin
      bus.hold  = (nbeats == hold_at) && (held < hold_len);
      if (bus.hold) held++;
      bus.start = poke && (nbeats == 5);
      if (bus.start) bus.value_in = 8'h3C;
      rst = (nbeats == rst_at);
      @(negedge clk);
      if (rst) begin
        rst_seen = 1;
        rst_after = {bus.busy, bus.data_valid, bus.done, bus.last};
        rst = 1'b0;
        @(negedge clk);
        rst_after2 = {bus.busy, bus.data_valid, bus.done, bus.last};
        break;
      end
      if (bus.hold && !bus.data_valid && bus.data_out == 0) held_invalid++;
      if (bus.data_valid) begin
        if (first_k < 0) first_k = k;
        if (nbeats < 32) beats[nbeats] = bus.data_out;
        ones += $countones(bus.data_out);
        if (bus.last) begin
          last_beat = nbeats; last_k = k; last_count++;
        end
        nbeats++;
        span = k - first_k + 1;
      end else if (bus.data_out != 0) begin
        bad_zero++;
      end
      if (bus.done) begin
        got_done = 1; done_count++;
        done_after_last = (k == last_k + 1);
        done_busy = bus.busy;
        bus.hold = 1'b0;
        bus.start = poke;
        bus.value_in = 8'hAA;
        @(negedge clk);
        bus.start = 1'b0;
        busy_after = bus.busy;
        done_after = bus.done;
        break;
      end
    end
    bus.hold = 1'b0; bus.start = 1'b0; rst = 1'b0;
  endtask

  initial begin
    logic [7:0] vals [8];
    vals = '{8'd0, 8'd1, 8'd7, 8'd100, 8'd129, 8'd200, 8'd254, 8'd255};
    rst = 1'b1; bus.start = 1'b0; bus.value_in = '0; bus.mode_in = 1'b0; bus.hold = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {bus.busy, bus.acc_clr, bus.data_valid, bus.last, bus.done}, 5'b0);
    check("reset_data", bus.data_out, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Unary, value 20: two full beats, then four ones in lanes 0-3.
    run_stream(8'd20, 1'b0, -1, 0, -1, 1'b0);
    check("u20_clr", clr_ok, 1'b1);
    check("u20_first_beat_latency", first_k, 0);
    check("u20_span", span, 32);
    check("u20_nbeats", nbeats, 32);
    check("u20_last_beat", last_beat, 31);
    check("u20_last_count", last_count, 1);
    check("u20_done_after_last", done_after_last, 1'b1);
    check("u20_done_busy", done_busy, 1'b1);
    check("u20_busy_after_done", busy_after, 1'b0);
    check("u20_done_one_cycle", done_after, 1'b0);
    check("u20_zero_when_invalid", bad_zero, 0);
    check("u20_ones", ones, 20);
    for (int b = 0; b < 32; b++)
      check($sformatf("u20_beat%0d", b), beats[b], (b < 2) ? 8'hFF : (b == 2) ? 8'h0F : 8'h00);

    // Bit-reversed, value 128: even lanes only.
    run_stream(8'd128, 1'b1, -1, 0, -1, 1'b0);
    check("r128_clr", clr_ok, 1'b1);
    check("r128_ones", ones, 128);
    for (int b = 0; b < 32; b++) check($sformatf("r128_beat%0d", b), beats[b], 8'h55);

    run_stream(8'd0, 1'b1, -1, 0, -1, 1'b0);
    check("r0_ones", ones, 0);
    check("r0_nbeats", nbeats, 32);

    // Only threshold 255 (beat 31, lane 7) is not below 255.
    run_stream(8'd255, 1'b1, -1, 0, -1, 1'b0);
    check("r255_ones", ones, 255);
    check("r255_beat30", beats[30], 8'hFF);
    check("r255_beat31", beats[31], 8'h7F);
    run_stream(8'd255, 1'b0, -1, 0, -1, 1'b0);
    check("u255_beat31", beats[31], 8'h7F);

    // Unary 85 with a 3-cycle hold before beat 10 (beat 10 = 0x1F).
    run_stream(8'd85, 1'b0, 10, 3, -1, 1'b0);
    check("hold_invalid_cycles", held_invalid, 3);
    check("hold_nbeats", nbeats, 32);
    check("hold_span", span, 35);
    check("hold_beat9", beats[9], 8'hFF);
    check("hold_beat10", beats[10], 8'h1F);
    check("hold_beat11", beats[11], 8'h00);
    check("hold_ones", ones, 85);
    check("hold_zero_when_invalid", bad_zero, 0);

    // start during RUN and in the DONE cycle is ignored.
    run_stream(8'd20, 1'b0, -1, 0, -1, 1'b1);
    check("poke_ones", ones, 20);
    check("poke_beat2", beats[2], 8'h0F);
    check("poke_beat3", beats[3], 8'h00);
    check("poke_busy_after_done", busy_after, 1'b0);
    run_stream(8'd100, 1'b0, -1, 0, -1, 1'b0);
    check("restart_clr", clr_ok, 1'b1);
    check("restart_ones", ones, 100);

    // Mid-stream reset.
    run_stream(8'd200, 1'b0, -1, 0, 15, 1'b0);
    check("rst_seen", rst_seen, 1'b1);
    check("rst_outputs", rst_after, 4'b0000);
    check("rst_outputs_next", rst_after2, 4'b0000);
    check("rst_no_done", got_done, 1'b0);
    check("rst_no_last", last_count, 0);
    run_stream(8'd200, 1'b1, -1, 0, -1, 1'b0);
    check("post_rst_ones", ones, 200);
    check("post_rst_nbeats", nbeats, 32);
    check("post_rst_done", got_done, 1'b1);

    // rst and start together: reset wins.
    rst = 1'b1; bus.start = 1'b1; bus.value_in = 8'd50;
    @(negedge clk);
    check("rst_start_busy", bus.busy, 1'b0);
    check("rst_start_clr", bus.acc_clr, 1'b0);
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    check("rst_start_idle", {bus.busy, bus.acc_clr}, 2'b00);

    for (int j = 0; j < 8; j++) begin
      for (int m = 0; m < 2; m++) begin
        run_stream(vals[j], m[0], -1, 0, -1, 1'b0);
        check($sformatf("total_v%0d_m%0d", vals[j], m), ones, 32'(vals[j]));
        check($sformatf("done_v%0d_m%0d", vals[j], m), got_done, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
